// File: rtl/jury_vote_tally_pkg.sv
// Shared definitions for the jury voting unit: vote and verdict codes,
// FSM state encoding and the verdict decision helper.
package jury_vote_tally_pkg;

  localparam logic [1:0] VOTE_NONE    = 2'b00;
  localparam logic [1:0] VOTE_FAVOUR  = 2'b01;
  localparam logic [1:0] VOTE_AGAINST = 2'b10;
  localparam logic [1:0] VOTE_ABSTAIN = 2'b11;

  localparam logic [1:0] VERD_PEND = 2'b00;
  localparam logic [1:0] VERD_APPR = 2'b01;
  localparam logic [1:0] VERD_REJ  = 2'b10;
  localparam logic [1:0] VERD_TIE  = 2'b11;

  // Widest tally the unit supports (up to 15 jurors).
  localparam int MAX_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VOTING,
    ST_DECIDE,
    ST_RESULT
  } state_e;

  // No counted votes means no quorum; an even split goes either way
  // depending on how the jury is configured to treat ties.
  function automatic logic [1:0] decide_verdict(input logic [MAX_CNT_W-1:0] yes_cnt,
                                                input logic [MAX_CNT_W-1:0] no_cnt,
                                                input logic               tie_mode);
    logic [1:0] verdict;
    if ((yes_cnt == '0) && (no_cnt == '0)) begin
      verdict = VERD_TIE;
    end else if (yes_cnt > no_cnt) begin
      verdict = VERD_APPR;
    end else if (no_cnt > yes_cnt) begin
      verdict = VERD_REJ;
    end else begin
      verdict = tie_mode ? VERD_TIE : VERD_REJ;
    end
    return verdict;
  endfunction

endpackage

// File: rtl/jury_vote_tally_juror_slot.sv
// One juror's lock flag. The first non-empty vote while enabled is taken;
// later inputs from the same juror are ignored until the slot is cleared.
module jury_vote_tally_juror_slot
  import jury_vote_tally_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] vote,
  output logic       locked,
  output logic       is_yes_new,
  output logic       is_no_new
);

  logic locked_q;
  logic locked_d;
  logic take_vote;

  // Decide whether this edge locks a fresh vote and what the flag becomes.
  always_comb begin
    take_vote = enable && !locked_q && (vote != VOTE_NONE);
    locked_d  = locked_q;
    if (clear) begin
      locked_d = 1'b0;
    end else if (take_vote) begin
      locked_d = 1'b1;
    end
  end

  assign is_yes_new = take_vote && (vote == VOTE_FAVOUR);
  assign is_no_new  = take_vote && (vote == VOTE_AGAINST);
  assign locked     = locked_q;

  // Lock flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/jury_vote_tally.sv
// Jury voting unit: opens a timed session on START, locks each juror's first
// vote, tallies favour/against and publishes a registered verdict with a
// one-cycle DONE pulse.
module jury_vote_tally
  import jury_vote_tally_pkg::*;
#(
  parameter int N_JURORS    = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TIE_MODE    = 0,
  localparam int CNT_W      = $clog2(N_JURORS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [2*N_JURORS-1:0] J,
  output logic                  BUSY,
  output logic [N_JURORS-1:0]   VOTED,
  output logic [CNT_W-1:0]      YES_CNT,
  output logic [CNT_W-1:0]      NO_CNT,
  output logic                  S1,
  output logic                  S0,
  output logic                  DONE
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        verd_q, verd_d;
  logic [CNT_W-1:0]  yes_cnt_q, yes_cnt_d;
  logic [CNT_W-1:0]  no_cnt_q, no_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [N_JURORS-1:0] voted;
  logic [N_JURORS-1:0] yes_new;
  logic [N_JURORS-1:0] no_new;
  logic                slot_clear;
  logic                slot_enable;
  logic [CNT_W-1:0]    yes_add;
  logic [CNT_W-1:0]    no_add;

  for (genvar i = 0; i < N_JURORS; i++) begin : g_slot
    jury_vote_tally_juror_slot u_slot (
      .clk        (CLK),
      .rst_n      (RST_N),
      .clear      (slot_clear),
      .enable     (slot_enable),
      .vote       (J[2*i +: 2]),
      .locked     (voted[i]),
      .is_yes_new (yes_new[i]),
      .is_no_new  (no_new[i])
    );
  end

  // Count how many jurors lock a favour / against vote on this edge.
  always_comb begin
    yes_add = '0;
    no_add  = '0;
    for (int i = 0; i < N_JURORS; i++) begin
      yes_add = yes_add + CNT_W'(yes_new[i]);
      no_add  = no_add  + CNT_W'(no_new[i]);
    end
  end

  // Session sequencing: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    verd_d      = verd_q;
    yes_cnt_d   = yes_cnt_q;
    no_cnt_d    = no_cnt_q;
    timer_d     = timer_q;
    slot_clear  = 1'b0;
    slot_enable = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (START) begin
          state_d    = ST_VOTING;
          busy_d     = 1'b1;
          slot_clear = 1'b1;
          yes_cnt_d  = '0;
          no_cnt_d   = '0;
          timer_d    = '0;
          verd_d     = VERD_PEND;
        end
      end
      ST_VOTING: begin
        slot_enable = 1'b1;
        busy_d      = 1'b1;
        yes_cnt_d   = yes_cnt_q + yes_add;
        no_cnt_d    = no_cnt_q + no_add;
        timer_d     = timer_q + TMR_W'(1);
        if ((&voted) || (timer_q == TMR_W'(TIMEOUT_CYC - 1))) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        state_d = ST_RESULT;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        verd_d  = decide_verdict(MAX_CNT_W'(yes_cnt_q), MAX_CNT_W'(no_cnt_q), TIE_MODE != 0);
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any session immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      verd_q    <= VERD_PEND;
      yes_cnt_q <= '0;
      no_cnt_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      verd_q    <= verd_d;
      yes_cnt_q <= yes_cnt_d;
      no_cnt_q  <= no_cnt_d;
      timer_q   <= timer_d;
    end
  end

  assign BUSY    = busy_q;
  assign VOTED   = voted;
  assign YES_CNT = yes_cnt_q;
  assign NO_CNT  = no_cnt_q;
  assign S1      = verd_q[1];
  assign S0      = verd_q[0];
  assign DONE    = done_q;

endmodule

// File: tb/tb_jury_vote_tally.sv
// Scoreboard bench for jury_vote_tally: two instances (tie->rejected and
// tie->tie) share the same stimulus; expected results are queued per session
// and checked by monitors whenever DONE is presented.
module tb_jury_vote_tally;

   localparam int N  = 4;
   localparam int T  = 20;
   localparam int CW = 3;

   typedef struct packed {
      logic [3:0]    voted;
      logic [CW-1:0] yes;
      logic [CW-1:0] no;
      logic [1:0]    verd;
   } exp_t;

   logic          clock = 1'b0;
   logic          rstN;
   logic          start;
   logic [2*N-1:0] j;

   logic          busy0, busy1, s1a, s0a, s1b, s0b, done0, done1;
   logic [N-1:0]  voted0, voted1;
   logic [CW-1:0] yes0, yes1, no0, no1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t pop0, pop1;
   logic prevDone0 = 1'b0;
   logic prevDone1 = 1'b0;

   int checks = 0;
   int errors = 0;

   jury_vote_tally #(.N_JURORS(N), .TIMEOUT_CYC(T), .TIE_MODE(0)) dut0 (
      .CLK(clock), .RST_N(rstN), .START(start), .J(j),
      .BUSY(busy0), .VOTED(voted0), .YES_CNT(yes0), .NO_CNT(no0),
      .S1(s1a), .S0(s0a), .DONE(done0)
   );

   jury_vote_tally #(.N_JURORS(N), .TIMEOUT_CYC(T), .TIE_MODE(1)) dut1 (
      .CLK(clock), .RST_N(rstN), .START(start), .J(j),
      .BUSY(busy1), .VOTED(voted1), .YES_CNT(yes1), .NO_CNT(no1),
      .S1(s1b), .S0(s0b), .DONE(done1)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor for the tie->rejected instance: every DONE consumes one expectation.
   always @(negedge clock) begin
      if (done0) begin
         if (prevDone0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut0 done pulse longer than one cycle");
         end else if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut0 unexpected done");
         end else begin
            pop0 = q0.pop_front();
            checkOutput("dut0 voted", 32'(voted0), 32'(pop0.voted));
            checkOutput("dut0 yes", 32'(yes0), 32'(pop0.yes));
            checkOutput("dut0 no", 32'(no0), 32'(pop0.no));
            checkOutput("dut0 verdict", 32'({s1a, s0a}), 32'(pop0.verd));
         end
      end
      prevDone0 = done0;
   end

   // Monitor for the tie->tie instance.
   always @(negedge clock) begin
      if (done1) begin
         if (prevDone1) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut1 done pulse longer than one cycle");
         end else if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut1 unexpected done");
         end else begin
            pop1 = q1.pop_front();
            checkOutput("dut1 voted", 32'(voted1), 32'(pop1.voted));
            checkOutput("dut1 yes", 32'(yes1), 32'(pop1.yes));
            checkOutput("dut1 no", 32'(no1), 32'(pop1.no));
            checkOutput("dut1 verdict", 32'({s1b, s0b}), 32'(pop1.verd));
         end
      end
      prevDone1 = done1;
   end

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " busy"}, 32'(busy0), 32'd0);
      checkOutput({tag, " voted"}, 32'(voted0), 32'd0);
      checkOutput({tag, " yes"}, 32'(yes0), 32'd0);
      checkOutput({tag, " no"}, 32'(no0), 32'd0);
      checkOutput({tag, " verdict"}, 32'({s1a, s0a}), 32'd0);
      checkOutput({tag, " done"}, 32'(done0), 32'd0);
   endtask

   // Wait, bounded, until the monitors have consumed every queued expectation.
   task automatic waitResult(input exp_t e0);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (q0.size() > 0 || q1.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout waiting for done pending=%0d/%0d", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
      @(negedge clock);
      checkOutput("result hold verdict", 32'({s1a, s0a}), 32'(e0.verd));
      checkOutput("result busy", 32'(busy0), 32'd0);
   endtask

   // One session: START, two vote vectors on consecutive cycles, then quiet.
   task automatic applyStimulus(input logic [7:0] v1, input logic [7:0] v2, input bit holdStart,
                                input exp_t e0, input exp_t e1);
      @(negedge clock);
      start = 1'b1;
      j = '0;
      @(posedge clock);
      #1;
      checkOutput("open verdict cleared", 32'({s1a, s0a}), 32'd0);
      checkOutput("open verdict cleared tie", 32'({s1b, s0b}), 32'd0);
      checkOutput("open busy", 32'(busy0), 32'd1);
      checkOutput("open voted cleared", 32'(voted0), 32'd0);
      q0.push_back(e0);
      q1.push_back(e1);
      @(negedge clock);
      start = holdStart;
      j = v1;
      @(negedge clock);
      j = v2;
      @(negedge clock);
      j = '0;
      start = 1'b0;
      waitResult(e0);
   endtask

   initial begin
      rstN  = 1'b0;
      start = 1'b0;
      j     = '0;
      #12;
      checkIdleOutputs("reset");
      @(negedge clock);
      rstN = 1'b1;
      @(negedge clock);
      checkIdleOutputs("idle after reset");

      // All four vote at once: three favour, one against.
      applyStimulus(8'b01_01_01_10, 8'h00, 1'b0, '{4'b1111, 3'd3, 3'd1, 2'b01}, '{4'b1111, 3'd3, 3'd1, 2'b01});
      // Two-two split.
      applyStimulus(8'b01_01_10_10, 8'h00, 1'b0, '{4'b1111, 3'd2, 3'd2, 2'b10}, '{4'b1111, 3'd2, 3'd2, 2'b11});
      // Everyone abstains: no quorum.
      applyStimulus(8'b11_11_11_11, 8'h00, 1'b0, '{4'b1111, 3'd0, 3'd0, 2'b11}, '{4'b1111, 3'd0, 3'd0, 2'b11});
      // START held high through voting must not restart the session.
      applyStimulus(8'b01_01_01_10, 8'h00, 1'b1, '{4'b1111, 3'd3, 3'd1, 2'b01}, '{4'b1111, 3'd3, 3'd1, 2'b01});
      // Juror 0 votes against then tries to switch; decision at timeout.
      applyStimulus(8'b00_00_00_10, 8'b00_00_00_01, 1'b0, '{4'b0001, 3'd0, 3'd1, 2'b10}, '{4'b0001, 3'd0, 3'd1, 2'b10});
      // Only juror 1 votes favour; decision at timeout.
      applyStimulus(8'b00_00_01_00, 8'h00, 1'b0, '{4'b0010, 3'd1, 3'd0, 2'b01}, '{4'b0010, 3'd1, 3'd0, 2'b01});
      // Votes spread over two cycles, juror 0 re-vote ignored.
      applyStimulus(8'b00_00_10_01, 8'b10_10_00_10, 1'b0, '{4'b1111, 3'd1, 3'd3, 2'b10}, '{4'b1111, 3'd1, 3'd3, 2'b10});

      // Reset in the middle of a session with two votes locked.
      @(negedge clock);
      start = 1'b1;
      j = '0;
      @(negedge clock);
      start = 1'b0;
      j = 8'b00_00_01_10;
      @(negedge clock);
      j = '0;
      checkOutput("mid voted", 32'(voted0), 32'b0011);
      checkOutput("mid yes", 32'(yes0), 32'd1);
      checkOutput("mid no", 32'(no0), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkIdleOutputs("abort");
      repeat (4) @(negedge clock);
      checkIdleOutputs("abort held");
      rstN = 1'b1;
      repeat (2) @(negedge clock);
      checkIdleOutputs("after abort");

      // The unit works normally again after the abort.
      applyStimulus(8'b10_01_01_01, 8'h00, 1'b0, '{4'b1111, 3'd3, 3'd1, 2'b01}, '{4'b1111, 3'd3, 3'd1, 2'b01});

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
